fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Program counter, instruction register and operand register of the 8-bit RISC CPU.
//  Drives the 4-bit opcode (ins) into the controller FSM.
//  Consumes the controller's fetch, PC_en, pc_chg_en, rom_read and ad_sel strobes.
//  Produces the ROM/RAM address: PC for instruction fetch, operand for data access.
// PARAMETERS
//  DATA_W  8  width of ROM data bus, IR and operand register
//  ADDR_W  8  width of PC, operand address and addr output (ADDR_W <= DATA_W)
//  RSEL_W  4  width of register-select field, ir[RSEL_W-1:0] (RSEL_W <= DATA_W-4)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous reset, active-low
//  data_in    in   DATA_W  ROM read data
//  fetch      in   2       01 load IR, 10 load operand, 00 hold, 11 illegal
//  rom_rd     in   1       ROM read strobe; gates every fetch load
//  pc_en      in   1       PC update enable
//  pc_chg_en  in   1       PC change; with pc_en = load PC from operand
//  ad_sel     in   1       0: addr = pc; 1: addr = opr
//  ins        out  4       opcode, ir[DATA_W-1:DATA_W-4]
//  reg_sel    out  RSEL_W  register select, ir[RSEL_W-1:0]
//  opr        out  ADDR_W  operand register, opr_q[ADDR_W-1:0]
//  pc         out  ADDR_W  program counter
//  addr       out  ADDR_W  memory address (combinational mux)
//  fetch_err  out  1       sticky illegal-fetch flag
// BEHAVIOUR
//  Reset (rst=0, async):
//   - pc=0, ir=0 (ins=NOP 4'b0000), opr_q=0, fetch_err=0.
//   - All outputs take these values immediately; an operation in progress is abandoned.
//   - After release, the first fetch is from address 0.
//  IR/operand, on posedge clk, only when rom_rd=1:
//   - fetch=01: ir <= data_in.
//   - fetch=10: opr_q <= data_in.
//   - fetch=00: hold.
//   - fetch=11: hold both registers and set fetch_err.
//   - rom_rd=0: no load, whatever fetch is; fetch=11 with rom_rd=0 does not set fetch_err.
//  PC, on posedge clk:
//   - pc_en=1 and pc_chg_en=0: pc <= pc+1, mod 2^ADDR_W (2^ADDR_W-1 wraps to 0).
//   - pc_en=1 and pc_chg_en=1: pc <= opr_q[ADDR_W-1:0] (jump), using the pre-edge opr_q.
//   - pc_en=0: hold, whatever pc_chg_en is (STO phase asserts pc_chg_en alone).
//  Simultaneous events:
//   - IR, operand and PC may all update on one edge; each uses pre-edge values.
//   - Jump plus operand reload on the same edge: PC takes the old opr_q, opr_q takes data_in.
//  Latency:
//   - ins, reg_sel, opr and pc are registered; each is valid the cycle after its load edge.
//   - addr is combinational from ad_sel, pc and opr_q, with zero latency.
//  fetch_err is cleared only by reset.
//  Expected sequences driven by the controller:
//   - Short instruction: S0 (fetch=01) loads IR; S1 (pc_en) increments PC.
//   - Long instruction: S3 (fetch=10) loads the operand at the incremented PC.
//   - LDO/LDA: S5 (pc_en) steps PC past the operand.
//   - JMP: S10 (pc_en, pc_chg_en, fetch=10) jumps to the operand.
//  No internal FSM state beyond the registers above.
// TESTING
//  1. Reset mid-run (pc=0x37, ir=0x5A): rst low -> pc=0, ins=0, opr=0, fetch_err=0 without a clock edge.
//  2. Short instruction: data_in=0x63, fetch=01, rom_rd=1, then pc_en=1 -> ins=4'h6, reg_sel=3, pc 0->1.
//  3. JMP: IR=0xE0; fetch=10 with data_in=0x40, then pc_en=pc_chg_en=1 -> pc=0x40; addr=0x40 with ad_sel=0.
//  4. STO phase: pc_chg_en=1, pc_en=0 -> pc unchanged; ad_sel=1 -> addr=opr.
//  5. Wrap: pc=0xFF with pc_en=1 -> pc=0x00.
//  6. fetch=11 with rom_rd=1 -> ir and opr unchanged, fetch_err=1 and held until reset.
//     rom_rd=0 with fetch=01 -> no IR load.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction register and operand register of the 8-bit RISC CPU
module fetch_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int RSEL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        fetch,
    input  logic              rom_rd,
    input  logic              pc_en,
    input  logic              pc_chg_en,
    input  logic              ad_sel,
    output logic [3:0]        ins,
    output logic [RSEL_W-1:0] reg_sel,
    output logic [ADDR_W-1:0] opr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] addr,
    output logic              fetch_err
);
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] opr_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= '0;
            ir        <= '0;
            opr_q     <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (rom_rd && fetch == 2'b01) ir <= data_in;
            if (rom_rd && fetch == 2'b10) opr_q <= data_in;
            if (rom_rd && fetch == 2'b11) fetch_err <= 1'b1;
            // a jump uses the pre-edge operand even when it is reloaded on the same edge
            if (pc_en) pc <= pc_chg_en ? opr_q[ADDR_W-1:0] : pc + ADDR_W'(1);
        end
    end
    assign ins     = ir[DATA_W-1 -: 4];
    assign reg_sel = ir[RSEL_W-1:0];
    assign opr     = opr_q[ADDR_W-1:0];
    assign addr    = ad_sel ? opr : pc;
endmodule
